// File: rtl/inverse_permute_unit.sv
// inverse_permute_unit: streams SLICES 25-bit slices (in_valid/in_ready in, out_valid/out_ready out) through the inverse Keccak pi-step, framed by start/busy/done
module inverse_permute_unit #(
  parameter int SLICES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [24:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [24:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);
  localparam int CW = SLICES > 1 ? $clog2(SLICES) : 1;
  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    WAIT_IN  = 5'b00010,
    PERMUTE  = 5'b00100,
    WAIT_OUT = 5'b01000,
    DONE     = 5'b10000
  } state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [24:0] in_reg, out_reg, inv;
  for (genvar u = 0; u < 5; u++) begin : g_u
    for (genvar v = 0; v < 5; v++) begin : g_v
      localparam int Y = ((2 * (u - v)) % 5 + 5) % 5;
      assign inv[5*v+u] = in_reg[5*Y+v];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      in_reg  <= '0;
      out_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) state <= WAIT_IN;
        end
        WAIT_IN: if (in_valid) begin
          in_reg <= in_data;
          state  <= PERMUTE;
        end
        PERMUTE: begin
          out_reg <= inv;
          state   <= WAIT_OUT;
        end
        WAIT_OUT: if (out_ready) begin
          if (cnt == CW'(SLICES - 1)) state <= DONE;
          else begin
            cnt   <= cnt + 1'b1;
            state <= WAIT_IN;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign in_ready  = state == WAIT_IN;
  assign out_valid = state == WAIT_OUT;
  assign out_data  = out_reg;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
endmodule

// File: tb/tb_inverse_permute_unit.sv
// tb_inverse_permute_unit: directed checks of inverse_permute_unit with SLICES=64 and SLICES=1 instances
module tb_inverse_permute_unit;
  logic clk = 0, rst = 0;
  logic start = 0, in_valid = 0, out_ready = 0;
  logic [24:0] in_data = '0;
  logic in_ready, out_valid, busy, done;
  logic [24:0] out_data;
  logic s_start = 0, s_in_valid = 0, s_out_ready = 0;
  logic [24:0] s_in_data = '0;
  logic s_in_ready, s_out_valid, s_busy, s_done;
  logic [24:0] s_out_data;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  inverse_permute_unit #(.SLICES(64)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .done(done)
  );
  inverse_permute_unit #(.SLICES(1)) dut1 (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_data(s_in_data),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
    .out_ready(s_out_ready), .busy(s_busy), .done(s_done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [24:0] fwd(input logic [24:0] a);
    logic [24:0] r = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[5*y+x] = a[5*x+(x+3*y)%5];
    return r;
  endfunction
  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask
  task automatic run1(input logic [24:0] din, input logic [24:0] exp);
    s_start = 1;
    s_in_valid = 0;
    step();
    s_start = 0;
    chk("s_in_ready", s_in_ready, 1);
    chk("s_busy", s_busy, 1);
    s_in_valid = 1;
    s_in_data = din;
    step();
    s_in_valid = 0;
    chk("s_permute_ov", s_out_valid, 0);
    chk("s_permute_ir", s_in_ready, 0);
    step();
    chk("s_out_valid", s_out_valid, 1);
    chk("s_out_data", s_out_data, exp);
    s_out_ready = 1;
    step();
    s_out_ready = 0;
    chk("s_done", s_done, 1);
    chk("s_done_ov", s_out_valid, 0);
    step();
    chk("s_done_len", s_done, 0);
    chk("s_idle_busy", s_busy, 0);
  endtask
  task automatic run64(input bit stall_en, input bit abort_en, input bit pulse_start);
    logic [24:0] d [64];
    int ni, no, stall, cyc, dcyc;
    bit fin;
    for (int i = 0; i < 64; i++) d[i] = 25'($urandom);
    ni = 0;
    no = 0;
    stall = 0;
    dcyc = 0;
    fin = 0;
    start = 1;
    in_valid = 1;
    in_data = 25'h1ffffff;
    out_ready = 1;
    step();
    start = 0;
    cyc = 2;
    while (!fin && cyc < 600) begin
      in_valid = ni < 64;
      in_data = ni < 64 ? fwd(d[ni]) : '0;
      out_ready = 1;
      start = pulse_start && cyc == 40;
      if (done) begin
        dcyc = cyc;
        fin = 1;
      end else begin
        if (abort_en && out_valid && no == 10) begin
          rst = 1;
          step();
          rst = 0;
          in_valid = 0;
          chk_zero("abort");
          for (int k = 0; k < 4; k++) begin
            step();
            chk("abort_no_done", done, 0);
            chk("abort_idle", busy, 0);
          end
          return;
        end
        if (stall_en && out_valid && no == 3 && stall < 5) begin
          out_ready = 0;
          stall++;
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, d[3]);
          chk("stall_in_ready", in_ready, 0);
        end else if (out_valid) begin
          chk("rt_data", out_data, d[no]);
          no++;
        end
        if (in_ready && in_valid) ni++;
      end
      step();
      cyc++;
    end
    chk("rt_done_seen", fin, 1);
    chk("rt_outs", no, 64);
    chk("rt_ins", ni, 64);
    chk("rt_cycles", dcyc, stall_en ? 199 : 194);
    chk("rt_done_len", done, 0);
    chk("rt_busy_after", busy, 0);
  endtask
  initial begin
    rst = 1;
    start = 1;
    in_valid = 1;
    s_start = 1;
    s_in_valid = 1;
    step();
    step();
    chk_zero("rst");
    chk("rst_s_in_ready", s_in_ready, 0);
    chk("rst_s_busy", s_busy, 0);
    chk("rst_s_out_data", s_out_data, 0);
    rst = 0;
    start = 0;
    in_valid = 0;
    s_start = 0;
    s_in_valid = 0;
    step();
    chk_zero("post_rst");
    chk("post_rst_s_busy", s_busy, 0);
    run1(25'h0000400, 25'h0000002);
    run1(25'h0010000, 25'h0000020);
    run1(25'h0000001, 25'h0000001);
    run1(fwd(25'h1234567), 25'h1234567);
    run64(0, 0, 0);
    run64(1, 0, 1);
    run64(0, 0, 0);
    run64(0, 1, 0);
    run64(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
